// File: rtl/multicycle_main_control_pkg.sv
// Shared encodings for the multicycle main control FSM and the ALU control decoder:
// state codes, opcodes, aluop values, mux selects and the control-word layout.
package multicycle_main_control_pkg;

  localparam int unsigned OPW  = 6;
  localparam int unsigned ST_W = 4;

  typedef enum logic [3:0] {
    StRst    = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StRtExe  = 4'd7,
    StRtWb   = 4'd8,
    StBeqEx  = 4'd9,
    StBlezEx = 4'd10,
    StAndiEx = 4'd11,
    StAndiWb = 4'd12,
    StJmorRd = 4'd13,
    StJmorPc = 4'd14,
    StTrap   = 4'd15
  } state_e;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_BLEZ  = 6'b000110;
  localparam logic [OPW-1:0] OP_ANDI  = 6'b001100;

  localparam logic [3:0] ALUOP_NONE  = 4'b0000;
  localparam logic [3:0] ALUOP_ADD   = 4'b1000;
  localparam logic [3:0] ALUOP_BEQ   = 4'b0001;
  localparam logic [3:0] ALUOP_BLEZ  = 4'b0101;
  localparam logic [3:0] ALUOP_ANDI  = 4'b0100;
  localparam logic [3:0] ALUOP_RTYPE = 4'b0010;

  localparam logic [1:0] ALUSRCB_RT      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_MDR    = 2'b11;

  typedef struct packed {
    logic [3:0] aluop;
    logic       pcwrite;
    logic       pcwritecond;
    logic       branch_lez;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic       illegal_op;
  } ctrl_t;

  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c       = '0;
    c.aluop = ALUOP_NONE;
    return c;
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control-word decoder for the multicycle main control FSM.
// The TRAP state only asserts illegal_op when ILLEGAL_OP_TRAP_EN is defined.
module mc_ctrl_outdec
  import multicycle_main_control_pkg::*;
#(
  parameter int unsigned ST_W = 4
) (
  input  logic [ST_W-1:0] state,
  output ctrl_t           ctrl
);

  always_comb begin
    ctrl = ctrl_idle();
    case (state_e'(state))
      StFetch: begin
        ctrl.memread  = 1'b1;
        ctrl.irwrite  = 1'b1;
        ctrl.alusrcb  = ALUSRCB_FOUR;
        ctrl.aluop    = ALUOP_ADD;
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCSRC_ALU;
      end
      StDecode: begin
        ctrl.alusrcb = ALUSRCB_IMM_SH2;
        ctrl.aluop   = ALUOP_ADD;
      end
      StMemAdr: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      StMemRd, StJmorRd: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      StMemWb: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      StMemWr: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      StRtExe: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_RT;
        ctrl.aluop   = ALUOP_RTYPE;
      end
      StRtWb: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      StBeqEx: begin
        ctrl.alusrca     = 1'b1;
        ctrl.aluop       = ALUOP_BEQ;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = PCSRC_ALUOUT;
      end
      StBlezEx: begin
        ctrl.alusrca     = 1'b1;
        ctrl.aluop       = ALUOP_BLEZ;
        ctrl.pcwritecond = 1'b1;
        ctrl.branch_lez  = 1'b1;
        ctrl.pcsource    = PCSRC_ALUOUT;
      end
      StAndiEx: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.aluop   = ALUOP_ANDI;
      end
      StAndiWb: begin
        ctrl.regwrite = 1'b1;
      end
      StJmorPc: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCSRC_MDR;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      StTrap: begin
        ctrl.illegal_op = 1'b1;
      end
`endif
      default: ctrl = ctrl_idle();
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Moore multicycle main control FSM: state register and next-state logic only.
// Optional trap on unknown opcodes is enabled by defining ILLEGAL_OP_TRAP_EN.
module multicycle_main_control
  import multicycle_main_control_pkg::*;
#(
  parameter int unsigned OPW  = 6,
  parameter int unsigned ST_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           jmorsig,
  input  logic           zero,
  output logic [3:0]     aluop,
  output logic           pcwrite,
  output logic           pcwritecond,
  output logic           branch_lez,
  output logic           iord,
  output logic           memread,
  output logic           memwrite,
  output logic           irwrite,
  output logic           memtoreg,
  output logic           regdst,
  output logic           regwrite,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsource,
  output logic           illegal_op
);

  state_e state_q;
  ctrl_t  ctrl;

  // zero feeds the datapath branch gate only
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRst;
    end else begin
      case (state_q)
        StRst:    state_q <= StFetch;
        StFetch:  state_q <= StDecode;
        StDecode: begin
          case (opcode)
            OP_LW, OP_SW: state_q <= StMemAdr;
            OP_RTYPE:     state_q <= StRtExe;
            OP_BEQ:       state_q <= StBeqEx;
            OP_BLEZ:      state_q <= StBlezEx;
            OP_ANDI:      state_q <= StAndiEx;
`ifdef ILLEGAL_OP_TRAP_EN
            default:      state_q <= StTrap;
`else
            default:      state_q <= StFetch;
`endif
          endcase
        end
        StMemAdr: state_q <= (opcode == OP_SW) ? StMemWr : StMemRd;
        StMemRd:  state_q <= StMemWb;
        StMemWb:  state_q <= StFetch;
        StMemWr:  state_q <= StFetch;
        StRtExe:  state_q <= jmorsig ? StJmorRd : StRtWb;
        StRtWb:   state_q <= StFetch;
        StBeqEx:  state_q <= StFetch;
        StBlezEx: state_q <= StFetch;
        StAndiEx: state_q <= StAndiWb;
        StAndiWb: state_q <= StFetch;
        StJmorRd: state_q <= StJmorPc;
        StJmorPc: state_q <= StFetch;
`ifdef ILLEGAL_OP_TRAP_EN
        StTrap:   state_q <= StTrap;
`endif
        default:  state_q <= StRst;
      endcase
    end
  end

  mc_ctrl_outdec #(
    .ST_W(ST_W)
  ) u_outdec (
    .state(state_q),
    .ctrl (ctrl)
  );

  assign aluop       = ctrl.aluop;
  assign pcwrite     = ctrl.pcwrite;
  assign pcwritecond = ctrl.pcwritecond;
  assign branch_lez  = ctrl.branch_lez;
  assign iord        = ctrl.iord;
  assign memread     = ctrl.memread;
  assign memwrite    = ctrl.memwrite;
  assign irwrite     = ctrl.irwrite;
  assign memtoreg    = ctrl.memtoreg;
  assign regdst      = ctrl.regdst;
  assign regwrite    = ctrl.regwrite;
  assign alusrca     = ctrl.alusrca;
  assign alusrcb     = ctrl.alusrcb;
  assign pcsource    = ctrl.pcsource;
  assign illegal_op  = ctrl.illegal_op;

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Moore-style multicycle main control FSM for the simple MIPS-like processor.
- Decodes the instruction opcode over several cycles and drives datapath enables plus the 4-bit aluop bus consumed by the ALU control decoder.
- Receives that decoder's jmorsig back, so the jmor R-type instruction can take its extra memory-indirect PC-load cycles.
- Sits between the instruction register and the datapath; it is the producer side of the aluop/jmorsig interface.

Parameters:
- OPW, 6, opcode width
- ST_W, 4, state register width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
- opcode  in  6  instr[31:26], valid from DECODE onward (IR held)
- jmorsig  in  1  from ALU control; high when R-type funct = 100110
- zero  in  1  ALU zero flag; datapath only, not consumed by the FSM
- aluop  out  4  {aluop3,aluop2,aluop1,aluop0} to ALU control
- pcwrite  out  1  unconditional PC load
- pcwritecond  out  1  conditional PC load (datapath gates with zero / blez compare)
- branch_lez  out  1  selects the blez condition instead of beq
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- memtoreg  out  1  register write data: 1 = MDR
- regdst  out  1  destination register: 1 = rd
- regwrite  out  1  register file write
- alusrca  out  1  ALU A input: 1 = rs
- alusrcb  out  2  ALU B input: 00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2
- pcsource  out  2  PC mux: 00 ALU, 01 ALUOut, 10 jump, 11 MDR (jmor)
- illegal_op  out  1  only when ILLEGAL_OP_TRAP_EN is defined; otherwise tied to 0

Behaviour:
- States: RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, BEQEX, BLEZEX, ANDIEX, ANDIWB, JMORRD, JMORPC, TRAP.
- Outputs are pure functions of the state register. No output depends combinationally on any input.
- Reset:
  - rst_n = 0 at a clock edge forces state RST, including mid-instruction.
  - In RST all outputs are 0 (aluop = 0000).
  - From RST, the first edge with rst_n = 1 moves to FETCH.
- FETCH:
  - Drives memread = 1, irwrite = 1, alusrcb = 01, aluop = 1000 (add), pcwrite = 1, pcsource = 00.
  - Next state: DECODE.
- DECODE:
  - Drives alusrcb = 11, aluop = 1000 (branch target add).
  - Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> RTEXE
    - 000100 (beq) -> BEQEX
    - 000110 (blez) -> BLEZEX
    - 001100 (andi) -> ANDIEX
    - anything else -> FETCH (NOP)
- MEMADR:
  - Drives alusrca = 1, alusrcb = 10, aluop = 1000.
  - Next state: MEMRD for lw, MEMWR for sw.
- MEMRD: memread = 1, iord = 1. Next state: MEMWB.
- MEMWB: regwrite = 1, memtoreg = 1, regdst = 0. Next state: FETCH.
- MEMWR: memwrite = 1, iord = 1. Next state: FETCH.
- RTEXE:
  - Drives alusrca = 1, alusrcb = 00, aluop = 0010.
  - Next state: JMORRD if jmorsig = 1, else RTWB. jmorsig is sampled at the end of this cycle.
- RTWB: regwrite = 1, regdst = 1. Next state: FETCH.
- BEQEX:
  - Drives alusrca = 1, aluop = 0001, pcwritecond = 1, pcsource = 01.
  - Next state: FETCH.
- BLEZEX:
  - Same as BEQEX but aluop = 0101 and branch_lez = 1.
  - Next state: FETCH.
- ANDIEX: alusrca = 1, alusrcb = 10, aluop = 0100. Next state: ANDIWB.
- ANDIWB: regwrite = 1, regdst = 0. Next state: FETCH.
- JMORRD: memread = 1, iord = 1. Next state: JMORPC.
- JMORPC: pcwrite = 1, pcsource = 11. Next state: FETCH.
- Instruction latencies in cycles, FETCH inclusive:
  - lw 5, sw 4, R 4, jmor 5, beq 3, blez 3, andi 4, unknown opcode 2.
- aluop is one-hot or zero on bits 3/2/0 except 0101. Never drive aluop1 together with any other bit.
- Unlisted states are unreachable; the default branch goes to RST.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE moves to TRAP.
  - TRAP holds all strobes at 0 and illegal_op = 1.
  - TRAP is left only by reset.
- Not defined:
  - No TRAP state; an unknown opcode returns to FETCH.
  - illegal_op is constantly 0.

Decomposition:
- Shared package holds:
  - state encodings (4-bit localparams)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BLEZ, OP_ANDI)
  - aluop constants (ALUOP_ADD = 1000, ALUOP_BEQ = 0001, ALUOP_BLEZ = 0101, ALUOP_ANDI = 0100, ALUOP_RTYPE = 0010)
  - alusrcb and pcsource encodings
- The ALU control decoder imports the same aluop constants.
- One natural sub-module: mc_ctrl_outdec, a combinational state -> control-word decoder.
- The FSM top keeps only the state register and next-state logic.

Test Plan:
- Reset, then lw (opcode 100011): states RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, back to FETCH. aluop = 1000 in MEMADR; regwrite = 1 and memtoreg = 1 only in MEMWB.
- R-type with jmorsig = 0, then with jmorsig = 1:
  - jmorsig = 0: 4 cycles, aluop = 0010 in RTEXE, RTWB has regdst = 1.
  - jmorsig = 1: JMORRD (memread = 1, iord = 1), then JMORPC (pcwrite = 1, pcsource = 11), 5 cycles total.
- beq, then blez:
  - beq: BEQEX has aluop = 0001, pcwritecond = 1, branch_lez = 0.
  - blez: aluop = 0101, branch_lez = 1.
  - Each takes 3 cycles.
- andi (001100), then sw (101011):
  - andi: aluop = 0100 and alusrcb = 10 in ANDIEX, then ANDIWB.
  - sw: MEMWR has memwrite = 1, memread = 0, 4 cycles.
- rst_n driven low during MEMRD: next edge is RST with all outputs 0. The first edge after release is FETCH. No regwrite pulse occurs.
- Opcode 111111:
  - Without ILLEGAL_OP_TRAP_EN: DECODE then FETCH, illegal_op = 0.
  - With ILLEGAL_OP_TRAP_EN: enters TRAP, illegal_op = 1 and held across 10 cycles, strobes stay 0 until reset.
